// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle controller and the shared datapath.
// master: controller side (drives selects/enables); slave: datapath side.
interface multicycle_control_if;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       reg_dst;
  logic       mem_2_reg;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [3:0] state;
  logic       instr_done;
  logic       illegal_op;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_cond, pc_source, i_or_d,
    output mem_read, mem_write, ir_write, reg_dst,
    output mem_2_reg, reg_write, alu_src_a, alu_src_b,
    output alu_op, state, instr_done, illegal_op
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_cond, pc_source, i_or_d,
    input  mem_read, mem_write, ir_write, reg_dst,
    input  mem_2_reg, reg_write, alu_src_a, alu_src_b,
    input  alu_op, state, instr_done, illegal_op
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: sequences fetch/decode/exec/mem/wb steps.
// Ports: clk, rst (sync, active-high), bus (master: opcode/mem_ready in,
// datapath selects, enables, state, instr_done, illegal_op out).
// Option: MEM_HANDSHAKE_EN makes FETCH/MEM_READ/MEM_WRITE wait on mem_ready.
module multicycle_control (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    R_WB      = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EXEC = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_2_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

  state_t state_q;
  state_t state_d;
  ctrl_t  c;
  ctrl_t  c_o;
  logic   mem_ok;

`ifdef MEM_HANDSHAKE_EN
  assign mem_ok = bus.mem_ready;
`else
  assign mem_ok = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  always_comb begin
    c       = '0;
    state_d = FETCH;
    unique case (state_q)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = 2'b01;
        if (mem_ok) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_d    = DECODE;
        end else begin
          state_d    = FETCH;
        end
      end
      DECODE: begin
        c.alu_src_b = 2'b11;
        unique case (1'b1)
          (bus.opcode == OP_LW),
          (bus.opcode == OP_SW):   state_d = MEM_ADDR;
          (bus.opcode == OP_R):    state_d = EXECUTE;
          (bus.opcode == OP_ADDI): state_d = ADDI_EXEC;
          (bus.opcode == OP_BEQ):  state_d = BRANCH;
          (bus.opcode == OP_J):    state_d = JUMP;
          default: begin
            c.illegal_op = 1'b1;
            state_d      = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d = (bus.opcode == OP_SW) ? MEM_WRITE : MEM_READ;
      end
      MEM_READ: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
        state_d    = mem_ok ? MEM_WB : MEM_READ;
      end
      MEM_WB: begin
        c.mem_2_reg  = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      MEM_WRITE: begin
        c.mem_write  = 1'b1;
        c.i_or_d     = 1'b1;
        c.instr_done = mem_ok;
        state_d      = mem_ok ? FETCH : MEM_WRITE;
      end
      EXECUTE: begin
        c.alu_src_a = 1'b1;
        c.alu_op    = 2'b10;
        state_d     = R_WB;
      end
      R_WB: begin
        c.reg_dst    = 1'b1;
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      ADDI_EXEC: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = 2'b10;
        state_d     = ADDI_WB;
      end
      ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
      end
      BRANCH: begin
        c.alu_src_a     = 1'b1;
        c.alu_op        = 2'b01;
        c.pc_write_cond = 1'b1;
        c.pc_source     = 2'b01;
        c.instr_done    = 1'b1;
      end
      JUMP: begin
        c.pc_write   = 1'b1;
        c.pc_source  = 2'b10;
        c.instr_done = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset level blanks every output, not just the state register.
  assign c_o = rst ? '0 : c;

  assign bus.state         = rst ? 4'd0 : state_q;
  assign bus.pc_write      = c_o.pc_write;
  assign bus.pc_write_cond = c_o.pc_write_cond;
  assign bus.pc_source     = c_o.pc_source;
  assign bus.i_or_d        = c_o.i_or_d;
  assign bus.mem_read      = c_o.mem_read;
  assign bus.mem_write     = c_o.mem_write;
  assign bus.ir_write      = c_o.ir_write;
  assign bus.reg_dst       = c_o.reg_dst;
  assign bus.mem_2_reg     = c_o.mem_2_reg;
  assign bus.reg_write     = c_o.reg_write;
  assign bus.alu_src_a     = c_o.alu_src_a;
  assign bus.alu_src_b     = c_o.alu_src_b;
  assign bus.alu_op        = c_o.alu_op;
  assign bus.instr_done    = c_o.instr_done;
  assign bus.illegal_op    = c_o.illegal_op;

endmodule

// File: tb/tb_multicycle_control.sv
// Scoreboard bench for multicycle_control: per-instruction expected traces
// from a step-list model, compared every cycle by a negedge monitor.
module tb_multicycle_control;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

`ifdef MEM_HANDSHAKE_EN
  localparam bit HS = 1'b1;
`else
  localparam bit HS = 1'b0;
`endif

  typedef struct packed {
    logic [3:0] st;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_2_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       instr_done;
    logic       illegal_op;
  } exp_t;

  typedef struct packed {
    logic rdy;
    logic hold;
  } drv_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic bit legal(logic [5:0] op);
    return op inside {6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};
  endfunction

  // Expected outputs of one step; stall marks a memory wait cycle.
  function automatic exp_t step(int s, bit stall, logic [5:0] op);
    exp_t e;
    e = '0;
    e.st = 4'(s);
    case (s)
      0: begin
        e.mem_read  = 1'b1;
        e.alu_src_b = 2'b01;
        e.ir_write  = !stall;
        e.pc_write  = !stall;
      end
      1: begin
        e.alu_src_b  = 2'b11;
        e.illegal_op = !legal(op);
      end
      2: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
      end
      3: begin
        e.mem_read = 1'b1;
        e.i_or_d   = 1'b1;
      end
      4: begin
        e.mem_2_reg  = 1'b1;
        e.reg_write  = 1'b1;
        e.instr_done = 1'b1;
      end
      5: begin
        e.mem_write  = 1'b1;
        e.i_or_d     = 1'b1;
        e.instr_done = !stall;
      end
      6: begin
        e.alu_src_a = 1'b1;
        e.alu_op    = 2'b10;
      end
      7: begin
        e.reg_dst    = 1'b1;
        e.reg_write  = 1'b1;
        e.instr_done = 1'b1;
      end
      8: begin
        e.alu_src_a     = 1'b1;
        e.alu_op        = 2'b01;
        e.pc_write_cond = 1'b1;
        e.pc_source     = 2'b01;
        e.instr_done    = 1'b1;
      end
      9: begin
        e.pc_write   = 1'b1;
        e.pc_source  = 2'b10;
        e.instr_done = 1'b1;
      end
      10: begin
        e.alu_src_a = 1'b1;
        e.alu_src_b = 2'b10;
      end
      11: begin
        e.reg_write  = 1'b1;
        e.instr_done = 1'b1;
      end
      default: e = '0;
    endcase
    return e;
  endfunction

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rst = 1'b1;
      bus.opcode = 6'($urandom);
      bus.mem_ready = 1'($urandom);
      sb.push_back('0);
    end
  endtask

  // wf/wm: memory wait cycles in FETCH and MEM_READ/MEM_WRITE.
  // cut>0: stop after that many steps (caller then resets).
  task automatic issue(input logic [5:0] op, input int wf,
                       input int wm, input int cut);
    int   ps[$];
    exp_t eq[$];
    drv_t dq[$];
    case (op)
      6'h00:   ps = '{0, 1, 6, 7};
      6'h08:   ps = '{0, 1, 10, 11};
      6'h04:   ps = '{0, 1, 8};
      6'h02:   ps = '{0, 1, 9};
      6'h23:   ps = '{0, 1, 2, 3, 4};
      6'h2B:   ps = '{0, 1, 2, 5};
      default: ps = '{0, 1};
    endcase
    if (cut > 0)
      while (ps.size() > cut) void'(ps.pop_back());
    foreach (ps[i]) begin
      int  s;
      int  w;
      bit  mem;
      bit  h;
      s   = ps[i];
      mem = (s == 0) || (s == 3) || (s == 5);
      h   = (s == 1) || (s == 2);
      w   = !HS ? 0 : (s == 0) ? wf : mem ? wm : 0;
      for (int k = 0; k < w; k++) begin
        eq.push_back(step(s, 1'b1, op));
        dq.push_back('{rdy: 1'b0, hold: h});
      end
      eq.push_back(step(s, 1'b0, op));
      dq.push_back('{rdy: (HS && mem) ? 1'b1 : 1'($urandom), hold: h});
    end
    foreach (dq[i]) begin
      @(posedge clk);
      #1;
      rst = 1'b0;
      if (i == 0)
        foreach (eq[j]) sb.push_back(eq[j]);
      bus.mem_ready = dq[i].rdy;
      bus.opcode = dq[i].hold ? op : 6'($urandom);
    end
  endtask

  always @(negedge clk) begin
    exp_t got;
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      got = {bus.state, bus.pc_write, bus.pc_write_cond, bus.pc_source,
             bus.i_or_d, bus.mem_read, bus.mem_write, bus.ir_write,
             bus.reg_dst, bus.mem_2_reg, bus.reg_write, bus.alu_src_a,
             bus.alu_src_b, bus.alu_op, bus.instr_done, bus.illegal_op};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t state got=%0d exp=%0d vec got=%h exp=%h",
                 $time, got.st, e.st, got, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  logic [5:0] ops [6] = '{6'h00, 6'h08, 6'h04, 6'h02, 6'h23, 6'h2B};

  initial begin
    logic [5:0] op;
    int idx;
    bus.opcode = 6'h00;
    bus.mem_ready = 1'b0;
    do_reset(3);
    issue(6'h00, 0, 0, 0);
    issue(6'h23, 0, 0, 0);
    issue(6'h2B, 0, 0, 0);
    issue(6'h04, 0, 0, 0);
    issue(6'h02, 0, 0, 0);
    issue(6'h3F, 0, 0, 0);
    issue(6'h08, 0, 0, 0);
    issue(6'h23, 0, 0, 3);
    do_reset(2);
    issue(6'h23, 0, 2, 0);
    issue(6'h2B, 1, 1, 0);
    repeat (80) begin
      idx = $urandom_range(0, 6);
      if (idx < 6) begin
        op = ops[idx];
      end else begin
        op = 6'($urandom);
        while (legal(op)) op = 6'($urandom);
      end
      if ($urandom_range(0, 9) == 0) begin
        issue(op, $urandom_range(0, 2), $urandom_range(0, 2),
              $urandom_range(1, 2));
        do_reset($urandom_range(1, 2));
      end else begin
        issue(op, $urandom_range(0, 2), $urandom_range(0, 2), 0);
      end
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain left=%0d exp=0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
